// File: rtl/tbird_sched_pkg.sv
// Shared definitions for the Thunderbird turn-signal scheduler: state
// encoding (identical to the external mode code), lamp pattern constants
// and the request arbitration rule.
package tbird_pkg;

  localparam logic [1:0] MODE_IDLE  = 2'd0;
  localparam logic [1:0] MODE_LEFT  = 2'd1;
  localparam logic [1:0] MODE_RIGHT = 2'd2;
  localparam logic [1:0] MODE_HAZ   = 2'd3;

  // State codes equal the mode codes so the state register drives mode directly.
  typedef enum logic [1:0] {
    ST_IDLE  = MODE_IDLE,
    ST_LEFT  = MODE_LEFT,
    ST_RIGHT = MODE_RIGHT,
    ST_HAZ   = MODE_HAZ
  } t_tbird_sched_state;

  // Directional sweep, bit0 is the lamp nearest the car centre.
  localparam logic [2:0] LEFT_PAT_S0 = 3'b001;
  localparam logic [2:0] LEFT_PAT_S1 = 3'b011;
  localparam logic [2:0] LEFT_PAT_S2 = 3'b111;
  localparam logic [2:0] LEFT_PAT_S3 = 3'b000;

  localparam logic [2:0] HAZ_PAT_ON  = 3'b111;
  localparam logic [2:0] HAZ_PAT_OFF = 3'b000;
  localparam logic [2:0] LAMPS_OFF   = 3'b000;
  localparam logic [2:0] LAMPS_ALL   = 3'b111;

  localparam logic [1:0] LR_LAST_STEP  = 2'd3;
  localparam logic [1:0] HAZ_LAST_STEP = 2'd1;

  // Both turn requests at once are treated as a hazard request.
  function automatic t_tbird_sched_state arbitrate(input logic l_req,
                                                   input logic r_req,
                                                   input logic h_req);
    t_tbird_sched_state win;
    if (h_req || (l_req && r_req)) begin
      win = ST_HAZ;
    end else if (l_req) begin
      win = ST_LEFT;
    end else if (r_req) begin
      win = ST_RIGHT;
    end else begin
      win = ST_IDLE;
    end
    return win;
  endfunction

  // Directional sweep pattern for a step; the right side uses the same values.
  function automatic logic [2:0] sweep_pat(input logic [1:0] step);
    logic [2:0] pat;
    case (step)
      2'd0:    pat = LEFT_PAT_S0;
      2'd1:    pat = LEFT_PAT_S1;
      2'd2:    pat = LEFT_PAT_S2;
      default: pat = LEFT_PAT_S3;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/tbird_tick_gen.sv
// Animation-step prescaler: counts 0..TICK_DIV-1 while run is high, held
// at zero otherwise; tick marks the last cycle of each step.
module tbird_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_b,
  input  logic run,
  output logic tick
);

  localparam logic [7:0] CNT_LAST = 8'(TICK_DIV - 1);

  logic [7:0] cnt_q;

  // Free-run while the scheduler is busy, wrapping at the step length.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q <= 8'd0;
    end else if (!run || (cnt_q == CNT_LAST)) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign tick = run && (cnt_q == CNT_LAST);

endmodule

// File: rtl/tbird_sched.sv
// Thunderbird tail-light scheduler: arbitrates left/right/hazard requests
// and sequences the lamp patterns one step every TICK_DIV clocks.
// Optional build macro TBIRD_SCHED_BRAKE_EN adds a brake input that
// forces the non-signalling side(s) fully on without touching the FSM.
module tbird_sched
  import tbird_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       haz_req,
`ifdef TBIRD_SCHED_BRAKE_EN
  input  logic       brake,
`endif
  output logic [2:0] l_lights,
  output logic [2:0] r_lights,
  output logic       busy,
  output logic [1:0] mode
);

  t_tbird_sched_state state_q, state_d, req_win;
  logic [1:0]         step_q, step_d;
  logic [2:0]         l_pat_q, r_pat_q, l_pat_d, r_pat_d;
  logic               busy_q;
  logic               tick;

  tbird_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_b (rst_b),
    .run   (busy_q),
    .tick  (tick)
  );

  // Next state/step: enter from IDLE at once, advance only on tick,
  // re-arbitrate at sequence end, hazard preempts a turn sweep on tick.
  always_comb begin
    req_win = arbitrate(left_req, right_req, haz_req);
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      ST_IDLE: begin
        state_d = req_win;
        step_d  = 2'd0;
      end
      ST_LEFT, ST_RIGHT: begin
        if (tick) begin
          if ((req_win == ST_HAZ) || (step_q == LR_LAST_STEP)) begin
            state_d = req_win;
            step_d  = 2'd0;
          end else begin
            step_d = step_q + 2'd1;
          end
        end
      end
      ST_HAZ: begin
        if (tick) begin
          if (step_q == HAZ_LAST_STEP) begin
            state_d = req_win;
            step_d  = 2'd0;
          end else begin
            step_d = step_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = 2'd0;
      end
    endcase
  end

  // Lamp patterns decoded from the next state so they can be registered
  // alongside it, keeping the outputs straight off flops.
  always_comb begin
    l_pat_d = LAMPS_OFF;
    r_pat_d = LAMPS_OFF;
    case (state_d)
      ST_LEFT:  l_pat_d = sweep_pat(step_d);
      ST_RIGHT: r_pat_d = sweep_pat(step_d);
      ST_HAZ: begin
        l_pat_d = (step_d == 2'd0) ? HAZ_PAT_ON : HAZ_PAT_OFF;
        r_pat_d = (step_d == 2'd0) ? HAZ_PAT_ON : HAZ_PAT_OFF;
      end
      default: begin
        l_pat_d = LAMPS_OFF;
        r_pat_d = LAMPS_OFF;
      end
    endcase
  end

  // State, step and registered Moore outputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= ST_IDLE;
      step_q  <= 2'd0;
      l_pat_q <= LAMPS_OFF;
      r_pat_q <= LAMPS_OFF;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      l_pat_q <= l_pat_d;
      r_pat_q <= r_pat_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign busy = busy_q;
  assign mode = state_q;

`ifdef TBIRD_SCHED_BRAKE_EN
  logic brake_l, brake_r;

  // Brake lights the side(s) not currently signalling; hazard is untouched.
  always_comb begin
    brake_l = brake && ((state_q == ST_IDLE) || (state_q == ST_RIGHT));
    brake_r = brake && ((state_q == ST_IDLE) || (state_q == ST_LEFT));
  end

  assign l_lights = brake_l ? LAMPS_ALL : l_pat_q;
  assign r_lights = brake_r ? LAMPS_ALL : r_pat_q;
`else
  assign l_lights = l_pat_q;
  assign r_lights = r_pat_q;
`endif

endmodule
